// File: rtl/formic_bctl_trc_pkg.sv
// Shared trace-path constants, used by the per-MBS capture buffers and the
// board-controller trace aggregator.
package formic_bctl_trc_pkg;

  localparam int unsigned TRC_REC_BYTES     = 8;
  localparam int unsigned TRC_CAP_DEPTH_LOG = 6;
  localparam int unsigned TRC_DCNT_W        = 16;

endpackage

// File: rtl/formic_bctl_trace_cap_if.sv
// MBS-side byte stream in, aggregator-side byte pop out, for one capture buffer.
interface formic_bctl_trace_cap_if
  import formic_bctl_trc_pkg::*;
#(
  parameter int unsigned DCNT_W = TRC_DCNT_W
);

  logic              i_valid;
  logic [7:0]        i_data;
  logic              i_deq;
  logic [7:0]        o_data;
  logic              o_data_valid;
  logic              o_drop;
  logic [DCNT_W-1:0] o_drop_cnt;

  modport master (
    output i_valid, i_data, i_deq,
    input  o_data, o_data_valid, o_drop, o_drop_cnt
  );

  modport slave (
    input  i_valid, i_data, i_deq,
    output o_data, o_data_valid, o_drop, o_drop_cnt
  );

endinterface

// File: rtl/formic_bctl_trc_mem.sv
// Byte regfile for the trace capture buffer: synchronous write, asynchronous
// read, intended for distributed RAM (no reset on the array).
module formic_bctl_trc_mem #(
  parameter int unsigned DEPTH_LOG = 6
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [DEPTH_LOG-1:0] waddr,
  input  logic [7:0]           wdata,
  input  logic [DEPTH_LOG-1:0] raddr,
  output logic [7:0]           rdata
);

  logic [7:0] mem_q [2**DEPTH_LOG];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/formic_bctl_trace_cap.sv
// Per-MBS trace capture: frames the byte stream into fixed records, commits
// only whole records and discards whole records on overflow.
module formic_bctl_trace_cap
  import formic_bctl_trc_pkg::*;
#(
  parameter int unsigned REC_BYTES = TRC_REC_BYTES,
  parameter int unsigned DEPTH_LOG = TRC_CAP_DEPTH_LOG,
  parameter int unsigned DCNT_W    = TRC_DCNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  formic_bctl_trace_cap_if.slave   trc
);

  localparam int unsigned FC_W        = $clog2(REC_BYTES);
  localparam int unsigned PTR_W       = DEPTH_LOG + 1;
  localparam int unsigned DEPTH_BYTES = 2**DEPTH_LOG;
  localparam int unsigned NSLOT       = DEPTH_BYTES / REC_BYTES;
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(REC_BYTES - 1);
  localparam logic [PTR_W-1:0] USED_MAX = PTR_W'(DEPTH_BYTES - REC_BYTES);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  cm_ptr_q, cm_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic              discard_q, discard_d;
  logic              drop_pending_q, drop_pending_d;
  logic [DCNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [NSLOT-1:0]  dropbit_q, dropbit_d;

  logic [PTR_W-1:0]  used;
  logic              discard_now;
  logic              data_valid;
  logic              mem_we;

  // Space check uses the registered read pointer, so a pop in the same cycle
  // frees space only for the next record start.
  assign used        = wr_ptr_q - rd_ptr_q;
  assign discard_now = (fcnt_q == '0) ? (used > USED_MAX) : discard_q;
  assign data_valid  = (cm_ptr_q != rd_ptr_q);

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    cm_ptr_d       = cm_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    fcnt_d         = fcnt_q;
    discard_d      = discard_q;
    drop_pending_d = drop_pending_q;
    drop_cnt_d     = drop_cnt_q;
    dropbit_d      = dropbit_q;
    mem_we         = 1'b0;

    if (trc.i_valid) begin
      fcnt_d    = fcnt_q + 1'b1;
      discard_d = discard_now;
      if (!discard_now) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (fcnt_q == FC_LAST) begin
        if (!discard_now) begin
          cm_ptr_d       = wr_ptr_q + 1'b1;
          dropbit_d[wr_ptr_q[DEPTH_LOG-1:FC_W]] = drop_pending_q;
          drop_pending_d = 1'b0;
        end else begin
          drop_pending_d = 1'b1;
          if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
        end
      end
    end

    if (trc.i_deq && data_valid) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      cm_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fcnt_q         <= '0;
      discard_q      <= 1'b0;
      drop_pending_q <= 1'b0;
      drop_cnt_q     <= '0;
      dropbit_q      <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      cm_ptr_q       <= cm_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fcnt_q         <= fcnt_d;
      discard_q      <= discard_d;
      drop_pending_q <= drop_pending_d;
      drop_cnt_q     <= drop_cnt_d;
      dropbit_q      <= dropbit_d;
    end
  end

  formic_bctl_trc_mem #(
    .DEPTH_LOG (DEPTH_LOG)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q[DEPTH_LOG-1:0]),
    .wdata (trc.i_data),
    .raddr (rd_ptr_q[DEPTH_LOG-1:0]),
    .rdata (trc.o_data)
  );

  assign trc.o_data_valid = data_valid;
  assign trc.o_drop       = dropbit_q[rd_ptr_q[DEPTH_LOG-1:FC_W]] & data_valid;
  assign trc.o_drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_formic_bctl_trace_cap.sv
// Scenario bench for the trace capture buffer: expected bytes/drop flags are
// queued as records are sent and compared as the aggregator side pops them.
module tb_formic_bctl_trace_cap;
  import formic_bctl_trc_pkg::*;

  typedef struct {
    logic [7:0] d;
    logic       drop;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  formic_bctl_trace_cap_if #(.DCNT_W(TRC_DCNT_W)) bus ();

  formic_bctl_trace_cap #(
    .REC_BYTES (TRC_REC_BYTES),
    .DEPTH_LOG (TRC_CAP_DEPTH_LOG),
    .DCNT_W    (TRC_DCNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .trc (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data  = 8'h00;
    bus.i_deq   = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    sb.delete();
  endtask

  // Send one full record back-to-back; queue it only if it is expected to be kept.
  task automatic send_rec(input logic [7:0] base, input bit keep, input bit drop);
    for (int i = 0; i < 8; i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 8'(base + 8'(i));
      if (keep) sb.push_back('{d: 8'(base + 8'(i)), drop: drop});
      cyc();
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic pop();
    bus.i_deq = 1'b1;
    cyc();
    bus.i_deq = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data  = 8'h00;
    bus.i_deq   = 1'b0;
    #3;
    checks++;
    if (bus.o_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.o_data_valid); end
    checks++;
    if (bus.o_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", bus.o_drop); end
    checks++;
    if (bus.o_drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.o_drop_cnt); end
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    exp_t e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 8'(8'h10 + 8'(i));
      sb.push_back('{d: 8'(8'h10 + 8'(i)), drop: 1'b0});
      cyc();
      if (i == 6) begin
        checks++;
        if (bus.o_data_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early got=%b exp=0", bus.o_data_valid); end
      end
    end
    bus.i_valid = 1'b0;
    checks++;
    if (bus.o_data_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_rise got=%b exp=1", bus.o_data_valid); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL basic_sb_empty got=0 exp=nonzero"); end
      else begin
        e = sb.pop_front();
        if (bus.o_data !== e.d || bus.o_drop !== e.drop || bus.o_data_valid !== 1'b1) begin
          errors++;
          $display("FAIL basic_byte%0d got=%h/%b/%b exp=%h/%b/1", i, bus.o_data, bus.o_drop, bus.o_data_valid, e.d, e.drop);
        end
      end
      pop();
    end
    checks++;
    if (bus.o_data_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_fall got=%b exp=0", bus.o_data_valid); end
  endtask

  task automatic test_partial_gap();
    exp_t e;
    int   bad;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 8'(8'h30 + 8'(i));
      sb.push_back('{d: 8'(8'h30 + 8'(i)), drop: 1'b0});
      cyc();
    end
    bus.i_valid = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.o_data_valid !== 1'b0) bad++;
      cyc();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL partial_valid_held got=%0d exp=0 cycles high", bad); end
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h37;
    sb.push_back('{d: 8'h37, drop: 1'b0});
    cyc();
    bus.i_valid = 1'b0;
    checks++;
    if (bus.o_data_valid !== 1'b1) begin errors++; $display("FAIL partial_valid_rise got=%b exp=1", bus.o_data_valid); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL partial_sb_empty got=0 exp=nonzero"); end
      else begin
        e = sb.pop_front();
        if (bus.o_data !== e.d || bus.o_drop !== e.drop) begin
          errors++;
          $display("FAIL partial_byte%0d got=%h/%b exp=%h/%b", i, bus.o_data, bus.o_drop, e.d, e.drop);
        end
      end
      pop();
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    do_reset();
    for (int r = 0; r < 8; r++) send_rec(8'(r * 16), 1'b1, 1'b0);
    checks++;
    if (bus.o_data_valid !== 1'b1) begin errors++; $display("FAIL ovf_full_valid got=%b exp=1", bus.o_data_valid); end
    send_rec(8'h80, 1'b0, 1'b0);
    send_rec(8'h90, 1'b0, 1'b0);
    checks++;
    if (bus.o_drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_cnt got=%0d exp=2", bus.o_drop_cnt); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      e = sb.pop_front();
      if (bus.o_data !== e.d || bus.o_drop !== e.drop) begin
        errors++;
        $display("FAIL ovf_rec1_byte%0d got=%h/%b exp=%h/%b", i, bus.o_data, bus.o_drop, e.d, e.drop);
      end
      pop();
    end
    cyc();
    send_rec(8'hA0, 1'b1, 1'b1);
    checks++;
    if (bus.o_drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_cnt_after got=%0d exp=2", bus.o_drop_cnt); end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL ovf_sb_empty got=0 exp=nonzero"); end
      else begin
        e = sb.pop_front();
        if (bus.o_data !== e.d || bus.o_drop !== e.drop || bus.o_data_valid !== 1'b1) begin
          errors++;
          $display("FAIL ovf_drain%0d got=%h/%b/%b exp=%h/%b/1", i, bus.o_data, bus.o_drop, bus.o_data_valid, e.d, e.drop);
        end
      end
      pop();
    end
    checks++;
    if (bus.o_data_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%b exp=0", bus.o_data_valid); end
  endtask

  task automatic test_back_to_back();
    int got;
    exp_t e;
    do_reset();
    got = 0;
    fork
      begin
        for (int r = 0; r < 40; r++) begin
          for (int i = 0; i < 8; i++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = 8'((r * 8 + i) ^ 8'h5A);
            sb.push_back('{d: 8'((r * 8 + i) ^ 8'h5A), drop: 1'b0});
            cyc();
          end
        end
        bus.i_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 2000 && got < 320; c++) begin
          if (bus.o_data_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL b2b_sb_empty got=0 exp=nonzero"); end
            else begin
              e = sb.pop_front();
              if (bus.o_data !== e.d || bus.o_drop !== e.drop) begin
                errors++;
                $display("FAIL b2b_byte%0d got=%h/%b exp=%h/%b", got, bus.o_data, bus.o_drop, e.d, e.drop);
              end
            end
            got++;
            bus.i_deq = 1'b1;
          end else begin
            bus.i_deq = 1'b0;
          end
          cyc();
        end
        bus.i_deq = 1'b0;
      end
    join
    checks++;
    if (got != 320) begin errors++; $display("FAIL b2b_timeout got=%0d exp=320 bytes", got); end
    checks++;
    if (bus.o_drop_cnt !== 16'd0) begin errors++; $display("FAIL b2b_cnt got=%0d exp=0", bus.o_drop_cnt); end
    checks++;
    if (bus.o_data_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b exp=0", bus.o_data_valid); end
  endtask

  task automatic test_async_reset();
    exp_t e;
    do_reset();
    for (int r = 0; r < 8; r++) send_rec(8'(r * 16 + 1), 1'b1, 1'b0);
    send_rec(8'hE0, 1'b0, 1'b0);
    for (int i = 0; i < 48; i++) begin
      e = sb.pop_front();
      pop();
    end
    cyc();
    for (int i = 0; i < 3; i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 8'(8'hC0 + 8'(i));
      cyc();
    end
    bus.i_valid = 1'b0;
    checks++;
    if (bus.o_data_valid !== 1'b1 || bus.o_drop_cnt !== 16'd1) begin
      errors++;
      $display("FAIL arst_pre got=%b/%0d exp=1/1", bus.o_data_valid, bus.o_drop_cnt);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.o_data_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", bus.o_data_valid); end
    checks++;
    if (bus.o_drop_cnt !== 16'd0) begin errors++; $display("FAIL arst_cnt got=%0d exp=0", bus.o_drop_cnt); end
    checks++;
    if (bus.o_drop !== 1'b0) begin errors++; $display("FAIL arst_drop got=%b exp=0", bus.o_drop); end
    #3 rst = 1'b0;
    sb.delete();
    cyc();
    send_rec(8'h50, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL arst_sb_empty got=0 exp=nonzero"); end
      else begin
        e = sb.pop_front();
        if (bus.o_data !== e.d || bus.o_drop !== e.drop || bus.o_data_valid !== 1'b1) begin
          errors++;
          $display("FAIL arst_byte%0d got=%h/%b/%b exp=%h/%b/1", i, bus.o_data, bus.o_drop, bus.o_data_valid, e.d, e.drop);
        end
      end
      pop();
    end
    checks++;
    if (bus.o_data_valid !== 1'b0) begin errors++; $display("FAIL arst_empty got=%b exp=0", bus.o_data_valid); end
  endtask

  task automatic test_deq_empty();
    exp_t e;
    int   bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      pop();
      if (bus.o_data_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL deq_empty_valid got=%0d exp=0 cycles high", bad); end
    send_rec(8'h68, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL deq_empty_sb got=0 exp=nonzero"); end
      else begin
        e = sb.pop_front();
        if (bus.o_data !== e.d || bus.o_drop !== e.drop || bus.o_data_valid !== 1'b1) begin
          errors++;
          $display("FAIL deq_empty_byte%0d got=%h/%b/%b exp=%h/%b/1", i, bus.o_data, bus.o_drop, bus.o_data_valid, e.d, e.drop);
        end
      end
      pop();
    end
    checks++;
    if (bus.o_data_valid !== 1'b0) begin errors++; $display("FAIL deq_empty_end got=%b exp=0", bus.o_data_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_gap();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    test_deq_empty();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
